// File: rtl/sram_bus_ctrl.sv
// Asynchronous-SRAM controller: turns a single-outstanding req/ack access into
// registered chip-select, output-enable, write and byte-enable strobes across NUM_BANKS banks.
module sram_bus_ctrl #(
    parameter int DATA_W      = 32,
    parameter int SRAM_AW     = 20,
    parameter int BANK_W      = 1,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [SRAM_AW+BANK_W-1:0]     addr_i,
    input  logic [DATA_W/8-1:0]           sel_i,
    input  logic [DATA_W-1:0]             wdata_i,
    output logic [DATA_W-1:0]             rdata_o,
    output logic                          ack_o,
    output logic                          busy_o,
    output logic [SRAM_AW-1:0]            sram_addr_o,
    output logic [(2**BANK_W)-1:0]        sram_ce_n_o,
    output logic                          sram_oe_n_o,
    output logic                          sram_we_n_o,
    output logic [DATA_W/8-1:0]           sram_be_n_o,
    output logic [DATA_W-1:0]             sram_data_o,
    input  logic [DATA_W-1:0]             sram_data_i,
    output logic                          sram_data_oe_o
);

    localparam int NUM_BANKS = 2 ** BANK_W;
    localparam int BE_W      = DATA_W / 8;
    localparam int AW        = SRAM_AW + BANK_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [BE_W-1:0]        sel_q, sel_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [NUM_BANKS-1:0]   ce_n_q, ce_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   we_n_q, we_n_d;
    logic [BE_W-1:0]        be_n_q, be_n_d;
    logic                   data_oe_q, data_oe_d;
    logic                   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic [NUM_BANKS-1:0]   ce_sel_s;
    logic [BANK_W-1:0]      bank_s;

    // Next-state logic: request capture in IDLE, wait counting in RD/WR_PULSE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    sel_d   = sel_i;
                    wdata_d = wdata_i;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = we_i ? WR_SETUP : RD;
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = sram_data_i;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_HOLD:  state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the state being entered so the pads see registered values.
    always_comb begin
        bank_s = addr_d[AW-1:SRAM_AW];
        for (int i = 0; i < NUM_BANKS; i++) begin
            ce_sel_s[i] = (int'(bank_s) != i);
        end
        ce_n_d    = {NUM_BANKS{1'b1}};
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        be_n_d    = {BE_W{1'b1}};
        data_oe_d = 1'b0;
        ack_d     = 1'b0;
        busy_d    = (state_d != IDLE);
        case (state_d)
            RD: begin
                ce_n_d = ce_sel_s;
                oe_n_d = 1'b0;
                be_n_d = {BE_W{1'b0}};
            end
            WR_SETUP, WR_HOLD: begin
                ce_n_d    = ce_sel_s;
                be_n_d    = ~sel_d;
                data_oe_d = 1'b1;
            end
            WR_PULSE: begin
                ce_n_d    = ce_sel_s;
                we_n_d    = 1'b0;
                be_n_d    = ~sel_d;
                data_oe_d = 1'b1;
            end
            DONE:    ack_d = 1'b1;
            IDLE:    ack_d = 1'b0;
            default: ack_d = 1'b0;
        endcase
    end

    // State, latched request and pad registers; reset forces every strobe inactive at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= {AW{1'b0}};
            sel_q     <= {BE_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            rdata_q   <= {DATA_W{1'b0}};
            ce_n_q    <= {NUM_BANKS{1'b1}};
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            be_n_q    <= {BE_W{1'b1}};
            data_oe_q <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            be_n_q    <= be_n_d;
            data_oe_q <= data_oe_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    assign rdata_o        = rdata_q;
    assign ack_o          = ack_q;
    assign busy_o         = busy_q;
    assign sram_addr_o    = addr_q[SRAM_AW-1:0];
    assign sram_ce_n_o    = ce_n_q;
    assign sram_oe_n_o    = oe_n_q;
    assign sram_we_n_o    = we_n_q;
    assign sram_be_n_o    = be_n_q;
    assign sram_data_o    = wdata_q;
    assign sram_data_oe_o = data_oe_q;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench: default controller against a small SRAM model, plus two
// BANK_W=2 instances (WAIT_CYCLES 0 and 3) for latency and bank-decode checks.
module tb_sram_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        we_s;
    logic [21:0] addr_s;
    logic [3:0]  sel_s;
    logic [31:0] wdata_s;
    logic        req_a, req_b, req_c;

    logic [31:0] rdata_a, dout_a, din_a;
    logic        ack_a, busy_a, oe_a, wen_a, doe_a;
    logic [19:0] saddr_a;
    logic [1:0]  ce_a;
    logic [3:0]  ben_a;

    logic [31:0] rdata_b, dout_b, rdata_c, dout_c;
    logic        ack_b, busy_b, oe_b, wen_b, doe_b;
    logic        ack_c, busy_c, oe_c, wen_c, doe_c;
    logic [19:0] saddr_b, saddr_c;
    logic [3:0]  ce_b, ben_b, ce_c, ben_c;

    int checks = 0;
    int errors = 0;

    sram_bus_ctrl #(.DATA_W(32), .SRAM_AW(20), .BANK_W(1), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_i(req_a), .we_i(we_s), .addr_i(addr_s[20:0]),
        .sel_i(sel_s), .wdata_i(wdata_s), .rdata_o(rdata_a), .ack_o(ack_a), .busy_o(busy_a),
        .sram_addr_o(saddr_a), .sram_ce_n_o(ce_a), .sram_oe_n_o(oe_a), .sram_we_n_o(wen_a),
        .sram_be_n_o(ben_a), .sram_data_o(dout_a), .sram_data_i(din_a), .sram_data_oe_o(doe_a));

    sram_bus_ctrl #(.DATA_W(32), .SRAM_AW(20), .BANK_W(2), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_i(req_b), .we_i(we_s), .addr_i(addr_s),
        .sel_i(sel_s), .wdata_i(wdata_s), .rdata_o(rdata_b), .ack_o(ack_b), .busy_o(busy_b),
        .sram_addr_o(saddr_b), .sram_ce_n_o(ce_b), .sram_oe_n_o(oe_b), .sram_we_n_o(wen_b),
        .sram_be_n_o(ben_b), .sram_data_o(dout_b), .sram_data_i(32'h0BAD_F00D), .sram_data_oe_o(doe_b));

    sram_bus_ctrl #(.DATA_W(32), .SRAM_AW(20), .BANK_W(2), .WAIT_CYCLES(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .req_i(req_c), .we_i(we_s), .addr_i(addr_s),
        .sel_i(sel_s), .wdata_i(wdata_s), .rdata_o(rdata_c), .ack_o(ack_c), .busy_o(busy_c),
        .sram_addr_o(saddr_c), .sram_ce_n_o(ce_c), .sram_oe_n_o(oe_c), .sram_we_n_o(wen_c),
        .sram_be_n_o(ben_c), .sram_data_o(dout_c), .sram_data_i(32'h0BAD_F00D), .sram_data_oe_o(doe_c));

    // SRAM model for dut_a: 256 words per bank, byte writes while ce_n and we_n are low.
    logic [31:0] mem [0:511];
    logic [8:0]  idx_s;
    logic        pl_en;
    logic [8:0]  pl_idx;
    logic [31:0] pl_val;
    assign idx_s = {~ce_a[1], saddr_a[7:0]};
    assign din_a = (!oe_a && ce_a != 2'b11) ? mem[idx_s] : 32'h0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (ce_a != 2'b11 && !wen_a) begin
            for (int k = 0; k < 4; k++) begin
                if (!ben_a[k]) mem[idx_s][8*k +: 8] <= dout_a[8*k +: 8];
            end
        end
    end

    task automatic preload(input logic [8:0] i, input logic [31:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = i; pl_val = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues one request on dut_a; returns the cycle ack was seen (0 if none within 30).
    task automatic issue_a(input logic we, input logic [21:0] a, input logic [3:0] s,
                           input logic [31:0] d, output int ack_cyc);
        @(negedge clk);
        we_s = we; addr_s = a; sel_s = s; wdata_s = d; req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        ack_cyc = 0;
        for (int c = 1; c <= 30; c++) begin
            if (ack_a) begin
                ack_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    // Same for the sweep instances; also captures ce_n in cycle 1.
    task automatic issue_sw(input int which, input logic we, input logic [21:0] a,
                            output int ack_cyc, output logic [3:0] ce1);
        @(negedge clk);
        we_s = we; addr_s = a; sel_s = 4'hF; wdata_s = 32'h5555_AAAA;
        if (which == 0) req_b = 1'b1; else req_c = 1'b1;
        @(posedge clk); #1;
        req_b = 1'b0; req_c = 1'b0;
        ce1 = (which == 0) ? ce_b : ce_c;
        ack_cyc = 0;
        for (int c = 1; c <= 30; c++) begin
            if ((which == 0) ? ack_b : ack_c) begin
                ack_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        logic [94:0] obs, exp;
        rst_n = 1'b0; req_a = 1'b1; we_s = 1'b1; addr_s = 22'h012345; sel_s = 4'hF; wdata_s = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        obs = {ce_a, oe_a, wen_a, ben_a, saddr_a, dout_a, doe_a, rdata_a, ack_a, busy_a};
        exp = {2'b11, 1'b1, 1'b1, 4'b1111, 20'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_outputs: got %h expected %h", obs, exp); end
        checks++;
        if (ce_b !== 4'b1111) begin errors++; $display("FAIL reset_ce_b: got %b expected 1111", ce_b); end
        @(negedge clk);
        req_a = 1'b0; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy_a, ack_a, ce_a} !== 4'b0011) begin
            errors++; $display("FAIL reset_release: got %b expected 0011", {busy_a, ack_a, ce_a});
        end
    endtask

    task automatic test_read;
        logic [10:0] obs, exp;
        preload(9'h045, 32'hDEAD_BEEF);
        @(negedge clk);
        we_s = 1'b0; addr_s = 22'h012345; sel_s = 4'b0001; req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            obs = {ce_a, oe_a, wen_a, ben_a, doe_a, ack_a, busy_a};
            case (c)
                1, 2:    exp = {2'b10, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1};
                3:       exp = {2'b11, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b1};
                default: exp = {2'b11, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0};
            endcase
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL read_cycle%0d: got %b expected %b", c, obs, exp); end
            if (c == 1) begin
                checks++;
                if (saddr_a !== 20'h12345) begin errors++; $display("FAIL read_addr: got %h expected 12345", saddr_a); end
            end
            if (c == 3) begin
                checks++;
                if (rdata_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data: got %h expected deadbeef", rdata_a); end
            end
        end
    endtask

    task automatic test_write;
        logic [10:0] obs, exp;
        preload(9'h145, 32'h1111_1111);
        @(negedge clk);
        we_s = 1'b1; addr_s = 22'h112345; sel_s = 4'b0011; wdata_s = 32'hCAFE_F00D; req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            obs = {ce_a, oe_a, wen_a, ben_a, doe_a, ack_a, busy_a};
            case (c)
                1, 4:    exp = {2'b01, 1'b1, 1'b1, 4'b1100, 1'b1, 1'b0, 1'b1};
                2, 3:    exp = {2'b01, 1'b1, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b1};
                5:       exp = {2'b11, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b1};
                default: exp = {2'b11, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0};
            endcase
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL write_cycle%0d: got %b expected %b", c, obs, exp); end
            if (c == 2) begin
                checks++;
                if (dout_a !== 32'hCAFE_F00D) begin errors++; $display("FAIL write_pad_data: got %h expected cafef00d", dout_a); end
            end
        end
        checks++;
        if (mem[9'h145] !== 32'h1111_F00D) begin errors++; $display("FAIL write_mem: got %h expected 1111f00d", mem[9'h145]); end
        checks++;
        if (rdata_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_keeps_rdata: got %h expected deadbeef", rdata_a); end
    endtask

    task automatic test_sel_zero;
        int cyc;
        preload(9'h020, 32'h7777_7777);
        issue_a(1'b1, 22'h000020, 4'b0000, 32'h1234_5678, cyc);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL sel0_latency: got %0d expected 5", cyc); end
        checks++;
        if (mem[9'h020] !== 32'h7777_7777) begin errors++; $display("FAIL sel0_mem: got %h expected 77777777", mem[9'h020]); end
    endtask

    task automatic test_back_to_back;
        int first_ack, second_ack, n_acks;
        first_ack = 0; second_ack = 0; n_acks = 0;
        @(negedge clk);
        we_s = 1'b1; addr_s = 22'h000010; sel_s = 4'hF; wdata_s = 32'hA5A5_5A5A; req_a = 1'b1;
        @(posedge clk); #1;
        we_s = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (ack_a) begin
                n_acks++;
                if (first_ack == 0) first_ack = c; else second_ack = c;
            end
            if (c == 6) begin
                checks++;
                if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%b expected 0", busy_a); end
            end
            if (c == 7) req_a = 1'b0;
            if (c == 9) begin
                checks++;
                if (rdata_a !== 32'hA5A5_5A5A) begin errors++; $display("FAIL b2b_rdata: got %h expected a5a55a5a", rdata_a); end
            end
        end
        checks++;
        if ({first_ack, second_ack, n_acks} !== {32'd5, 32'd9, 32'd2}) begin
            errors++; $display("FAIL b2b_acks: got %0d/%0d count %0d expected 5/9 count 2", first_ack, second_ack, n_acks);
        end
    endtask

    task automatic test_mid_reset;
        int n_acks, cyc;
        n_acks = 0;
        @(negedge clk);
        we_s = 1'b1; addr_s = 22'h000030; sel_s = 4'hF; wdata_s = 32'h0; req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (wen_a !== 1'b0) begin errors++; $display("FAIL midrst_in_pulse: got we_n=%b expected 0", wen_a); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({wen_a, ce_a, doe_a, busy_a} !== 5'b11100) begin
            errors++; $display("FAIL midrst_strobes: got %b expected 11100", {wen_a, ce_a, doe_a, busy_a});
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (ack_a) n_acks++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (ack_a) n_acks++;
        end
        checks++;
        if (n_acks !== 0) begin errors++; $display("FAIL midrst_no_ack: got %0d acks expected 0", n_acks); end
        issue_a(1'b0, 22'h012345, 4'hF, 32'h0, cyc);
        checks++;
        if (cyc !== 3) begin errors++; $display("FAIL midrst_next_latency: got %0d expected 3", cyc); end
        checks++;
        if (rdata_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL midrst_next_rdata: got %h expected deadbeef", rdata_a); end
    endtask

    task automatic test_sweep;
        int cyc;
        logic [3:0] ce1;
        issue_sw(0, 1'b0, 22'h300004, cyc, ce1);
        checks++;
        if ({cyc[7:0], ce1} !== {8'd2, 4'b0111}) begin errors++; $display("FAIL w0_read: got lat %0d ce %b expected 2 0111", cyc, ce1); end
        checks++;
        if (rdata_b !== 32'h0BAD_F00D) begin errors++; $display("FAIL w0_rdata: got %h expected 0badf00d", rdata_b); end
        issue_sw(0, 1'b1, 22'h100004, cyc, ce1);
        checks++;
        if ({cyc[7:0], ce1} !== {8'd4, 4'b1101}) begin errors++; $display("FAIL w0_write: got lat %0d ce %b expected 4 1101", cyc, ce1); end
        issue_sw(1, 1'b0, 22'h300004, cyc, ce1);
        checks++;
        if ({cyc[7:0], ce1} !== {8'd5, 4'b0111}) begin errors++; $display("FAIL w3_read: got lat %0d ce %b expected 5 0111", cyc, ce1); end
        checks++;
        if (rdata_c !== 32'h0BAD_F00D) begin errors++; $display("FAIL w3_rdata: got %h expected 0badf00d", rdata_c); end
        issue_sw(1, 1'b1, 22'h200004, cyc, ce1);
        checks++;
        if ({cyc[7:0], ce1} !== {8'd7, 4'b1011}) begin errors++; $display("FAIL w3_write: got lat %0d ce %b expected 7 1011", cyc, ce1); end
    endtask

    initial begin
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        we_s = 1'b0; addr_s = 22'h0; sel_s = 4'h0; wdata_s = 32'h0;
        pl_en = 1'b0; pl_idx = 9'h0; pl_val = 32'h0;
        test_reset();
        test_read();
        test_write();
        test_sel_zero();
        test_back_to_back();
        test_mid_reset();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
